acc_reg_file: RTL and testbench

- Parametrised successor to the 8 x 16-bit accumulator register file that feeds the ALU datapath.
- Holds NUM_REGS general registers plus one accumulator (res) with:
  - ALU write-back
  - copy-in (res -> reg) and copy-out (reg -> res)
  - compare flags
- Adds a streaming context save/restore engine with valid/ready handshakes, used by the trap/context-switch sequencer.

---
 rtl/acc_reg_file_pkg.sv | 21 ++
 rtl/acc_reg_file_ctx_seq.sv | 84 ++++++++
 rtl/acc_reg_file.sv | 96 +++++++++
 tb/tb_acc_reg_file.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_reg_file_pkg.sv
// Shared types and constants for the accumulator register file and its
// context save/restore sequencer.
package acc_reg_file_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;

    // Context sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2,
        DONE    = 2'd3
    } ctx_state_t;

    // Number of words in one context: every general register plus res.
    function automatic int ctx_words(input int num_regs);
        return num_regs + 1;
    endfunction

endpackage

// File: rtl/acc_reg_file_ctx_seq.sv
// Context save/restore sequencer: FSM, word index and handshake outputs.
// Drives a word index and a fill write strobe into the storage in the top.
module ctx_seq
    import acc_reg_file_pkg::*;
#(
    parameter  int NUM_REGS = DEF_NUM_REGS,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             save_req,
    input  logic             restore_req,
    input  logic             spill_ready,
    input  logic             fill_valid,
    output logic             spill_valid,
    output logic             fill_ready,
    output logic             busy,
    output logic             ctx_done,
    output logic [SEL_W:0]   word_idx,
    output logic             word_we
);

    // Index of the final word (res) in the context sequence.
    localparam logic [SEL_W:0] LAST_IDX = (SEL_W + 1)'(ctx_words(NUM_REGS) - 1);
    localparam logic [SEL_W:0] IDX_ONE  = (SEL_W + 1)'(1);

    ctx_state_t     state, state_next;
    logic [SEL_W:0] idx, idx_next;

    // Next-state and index update; index is cleared on every entry from IDLE.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (save_req) begin
                    state_next = SAVE;
                    idx_next   = '0;
                end else if (restore_req) begin
                    state_next = RESTORE;
                    idx_next   = '0;
                end
            end
            SAVE: begin
                if (spill_ready) begin
                    if (idx == LAST_IDX) state_next = DONE;
                    else                 idx_next   = idx + IDX_ONE;
                end
            end
            RESTORE: begin
                if (fill_valid) begin
                    if (idx == LAST_IDX) state_next = DONE;
                    else                 idx_next   = idx + IDX_ONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and index registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all clocked state avoid ordering races.
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Handshake and status outputs decode directly from the registered state.
    always_comb begin
        spill_valid = (state == SAVE);
        fill_ready  = (state == RESTORE);
        busy        = (state != IDLE);
        ctx_done    = (state == DONE);
        word_we     = (state == RESTORE) && fill_valid;
        word_idx    = idx;
    end

endmodule

// File: rtl/acc_reg_file.sv
// Parametrised accumulator register file: NUM_REGS general registers plus the
// accumulator res, with ALU write-back, copy-in/out, compare flags and a
// streaming context save/restore port.
// Optional macro ACC_REG_FILE_BYPASS_EN: forwards res onto reg_val during cpyin.
module acc_reg_file
    import acc_reg_file_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_REGS = DEF_NUM_REGS,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_we,
    input  logic [DATA_W-1:0] write_data,
    input  logic              cpyin,
    input  logic              cpyout,
    input  logic              comp,
    input  logic [SEL_W-1:0]  reg_sel,
    output logic [DATA_W-1:0] res_val,
    output logic [DATA_W-1:0] reg_val,
    output logic              eq_flag,
    output logic              lt_flag,
    input  logic              save_req,
    input  logic              restore_req,
    output logic              spill_valid,
    input  logic              spill_ready,
    output logic [DATA_W-1:0] spill_data,
    input  logic              fill_valid,
    output logic              fill_ready,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              ctx_done
);

    localparam logic [SEL_W:0] RES_IDX = (SEL_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] res;
    logic [SEL_W:0]    word_idx;
    logic              word_we;

    ctx_seq #(
        .NUM_REGS (NUM_REGS)
    ) u_ctx_seq (
        .clk         (clk),
        .reset       (reset),
        .save_req    (save_req),
        .restore_req (restore_req),
        .spill_ready (spill_ready),
        .fill_valid  (fill_valid),
        .spill_valid (spill_valid),
        .fill_ready  (fill_ready),
        .busy        (busy),
        .ctx_done    (ctx_done),
        .word_idx    (word_idx),
        .word_we     (word_we)
    );

    // Register/accumulator update: fill writes while busy, normal ops in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the array is flip-flops, not RAM, so clearing it in reset is legal and required.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            res     <= '0;
            eq_flag <= 1'b0;
            lt_flag <= 1'b0;
        end else if (busy) begin
            if (word_we) begin
                if (word_idx == RES_IDX) res <= fill_data;
                else                     regs[word_idx[SEL_W-1:0]] <= fill_data;
            end
        end else begin
            // cpyout wins over alu_we; with cpyin both sides read old values, giving a swap.
            if (cpyout)      res <= regs[reg_sel];
            else if (alu_we) res <= write_data;
            if (cpyin)       regs[reg_sel] <= res;
            if (comp) begin
                eq_flag <= (res == regs[reg_sel]);
                lt_flag <= ($signed(res) < $signed(regs[reg_sel]));
            end
        end
    end

    // Read paths: register read (optionally forwarded) and the current spill word.
    always_comb begin
`ifdef ACC_REG_FILE_BYPASS_EN
        reg_val = (cpyin && !busy) ? res : regs[reg_sel];
`else
        reg_val = regs[reg_sel];
`endif
        res_val    = res;
        spill_data = (word_idx == RES_IDX) ? res : regs[word_idx[SEL_W-1:0]];
    end

endmodule

// File: tb/tb_acc_reg_file.sv
// Directed self-checking bench for acc_reg_file (default parameters).
module tb_acc_reg_file;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_we = 1'b0;
    logic [15:0] write_data = '0;
    logic        cpyin = 1'b0;
    logic        cpyout = 1'b0;
    logic        comp = 1'b0;
    logic [2:0]  reg_sel = '0;
    logic [15:0] res_val;
    logic [15:0] reg_val;
    logic        eq_flag;
    logic        lt_flag;
    logic        save_req = 1'b0;
    logic        restore_req = 1'b0;
    logic        spill_valid;
    logic        spill_ready = 1'b0;
    logic [15:0] spill_data;
    logic        fill_valid = 1'b0;
    logic        fill_ready;
    logic [15:0] fill_data = '0;
    logic        busy;
    logic        ctx_done;

    int checks = 0;
    int errors = 0;

    acc_reg_file dut (
        .clk         (clk),
        .reset       (reset),
        .alu_we      (alu_we),
        .write_data  (write_data),
        .cpyin       (cpyin),
        .cpyout      (cpyout),
        .comp        (comp),
        .reg_sel     (reg_sel),
        .res_val     (res_val),
        .reg_val     (reg_val),
        .eq_flag     (eq_flag),
        .lt_flag     (lt_flag),
        .save_req    (save_req),
        .restore_req (restore_req),
        .spill_valid (spill_valid),
        .spill_ready (spill_ready),
        .spill_data  (spill_data),
        .fill_valid  (fill_valid),
        .fill_ready  (fill_ready),
        .fill_data   (fill_data),
        .busy        (busy),
        .ctx_done    (ctx_done)
    );

    always #10 clk = ~clk;

    // Advance one clock edge; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_res(input logic [15:0] v);
        alu_we = 1'b1; write_data = v;
        tick();
        alu_we = 1'b0;
    endtask

    task automatic copy_in(input int sel);
        cpyin = 1'b1; reg_sel = 3'(sel);
        tick();
        cpyin = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (res_val !== 16'h0 || eq_flag !== 1'b0 || lt_flag !== 1'b0) begin
            errors++; $display("FAIL reset_res_flags got res=%h eq=%b lt=%b exp 0000/0/0", res_val, eq_flag, lt_flag);
        end
        checks++;
        if ({busy, spill_valid, fill_ready, ctx_done} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctl got %b exp 0000", {busy, spill_valid, fill_ready, ctx_done});
        end
    endtask

    task automatic test_alu();
        load_res(16'h1234);
        checks++;
        if (res_val !== 16'h1234) begin
            errors++; $display("FAIL alu_we got %h exp 1234", res_val);
        end
        for (int i = 0; i < 8; i++) begin
            reg_sel = 3'(i); #1;
            checks++;
            if (reg_val !== 16'h0) begin
                errors++; $display("FAIL reg_zero[%0d] got %h exp 0000", i, reg_val);
            end
        end
    endtask

    task automatic test_copy();
        load_res(16'h00AA);
        copy_in(3);
        reg_sel = 3'd3; #1;
        checks++;
        if (reg_val !== 16'h00AA) begin
            errors++; $display("FAIL cpyin got %h exp 00aa", reg_val);
        end
        load_res(16'h0055);
        cpyin = 1'b1; cpyout = 1'b1; reg_sel = 3'd3;
        tick();
        cpyin = 1'b0; cpyout = 1'b0;
        checks++;
        if (res_val !== 16'h00AA || reg_val !== 16'h0055) begin
            errors++; $display("FAIL swap got res=%h reg3=%h exp 00aa/0055", res_val, reg_val);
        end
        // cpyout has priority over alu_we in the same cycle.
        cpyout = 1'b1; alu_we = 1'b1; write_data = 16'h1111;
        tick();
        cpyout = 1'b0; alu_we = 1'b0;
        checks++;
        if (res_val !== 16'h0055) begin
            errors++; $display("FAIL cpyout_prio got %h exp 0055", res_val);
        end
    endtask

    task automatic test_comp();
        load_res(16'h0001);
        copy_in(2);
        load_res(16'hFFFF);
        comp = 1'b1; reg_sel = 3'd2;
        tick();
        comp = 1'b0;
        checks++;
        if (lt_flag !== 1'b1 || eq_flag !== 1'b0) begin
            errors++; $display("FAIL comp_lt got lt=%b eq=%b exp 1/0", lt_flag, eq_flag);
        end
        load_res(16'h0001);
        checks++;
        if (lt_flag !== 1'b1 || eq_flag !== 1'b0) begin
            errors++; $display("FAIL comp_hold got lt=%b eq=%b exp 1/0", lt_flag, eq_flag);
        end
        comp = 1'b1;
        tick();
        comp = 1'b0;
        checks++;
        if (lt_flag !== 1'b0 || eq_flag !== 1'b1) begin
            errors++; $display("FAIL comp_eq got lt=%b eq=%b exp 0/1", lt_flag, eq_flag);
        end
    endtask

    task automatic test_save();
        logic [15:0] exp_w [9];
        int got = 0;
        int done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            load_res(16'(i + 1));
            copy_in(i);
            exp_w[i] = 16'(i + 1);
        end
        exp_w[8] = 16'h9999;
        load_res(16'h9999);
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        for (int c = 0; c < 60; c++) begin
            alu_we = 1'b1; write_data = 16'hDEAD;
            restore_req = (c == 3);
            spill_ready = 1'b0;
            if (spill_valid) begin
                checks++;
                if (got > 8) begin
                    errors++; $display("FAIL spill_extra got word %0d exp at most 9", got + 1);
                end else if (spill_data !== exp_w[got]) begin
                    errors++; $display("FAIL spill_word[%0d] got %h exp %h", got, spill_data, exp_w[got]);
                end
                spill_ready = (c % 2 == 0);
                if (spill_ready) got++;
            end
            if (ctx_done) done_cnt++;
            tick();
        end
        alu_we = 1'b0; restore_req = 1'b0; spill_ready = 1'b0;
        checks++;
        if (got !== 9 || done_cnt !== 1) begin
            errors++; $display("FAIL save_count got words=%0d done=%0d exp 9/1", got, done_cnt);
        end
        checks++;
        if (busy !== 1'b0 || res_val !== 16'hDEAD) begin
            errors++; $display("FAIL save_after got busy=%b res=%h exp 0/dead", busy, res_val);
        end
    endtask

    task automatic test_restore();
        int fed = 0;
        int done_cnt = 0;
        logic prev_done = 1'b0;
        restore_req = 1'b1;
        tick();
        restore_req = 1'b0;
        for (int c = 0; c < 60; c++) begin
            fill_valid = (c % 3 != 1) && (fed < 9);
            fill_data  = 16'hA000 + 16'(fed);
            if (fill_ready && fill_valid) fed++;
            if (ctx_done) begin
                done_cnt++;
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL busy_in_done got %b exp 1", busy);
                end
            end
            if (prev_done) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++; $display("FAIL busy_after_done got %b exp 0", busy);
                end
            end
            prev_done = ctx_done;
            tick();
        end
        fill_valid = 1'b0;
        checks++;
        if (fed !== 9 || done_cnt !== 1) begin
            errors++; $display("FAIL restore_count got words=%0d done=%0d exp 9/1", fed, done_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            reg_sel = 3'(i); #1;
            checks++;
            if (reg_val !== 16'hA000 + 16'(i)) begin
                errors++; $display("FAIL restore_reg[%0d] got %h exp %h", i, reg_val, 16'hA000 + 16'(i));
            end
        end
        checks++;
        if (res_val !== 16'hA008) begin
            errors++; $display("FAIL restore_res got %h exp a008", res_val);
        end
    endtask

    task automatic test_reset_abort();
        int got = 0;
        logic hit = 1'b0;
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            spill_ready = 1'b1;
            if (spill_valid && got == 3) begin
                reset = 1'b1;
                hit = 1'b1;
            end else if (spill_valid) begin
                got++;
            end
            tick();
        end
        reset = 1'b0; spill_ready = 1'b0;
        checks++;
        if (!hit) begin
            errors++; $display("FAIL abort_reach got words=%0d exp 3 before 4th", got);
        end
        checks++;
        if (busy !== 1'b0 || spill_valid !== 1'b0 || ctx_done !== 1'b0) begin
            errors++; $display("FAIL abort_ctl got busy=%b sv=%b done=%b exp 0/0/0", busy, spill_valid, ctx_done);
        end
        for (int i = 0; i < 8; i++) begin
            reg_sel = 3'(i); #1;
            checks++;
            if (reg_val !== 16'h0) begin
                errors++; $display("FAIL abort_reg[%0d] got %h exp 0000", i, reg_val);
            end
        end
        checks++;
        if (res_val !== 16'h0) begin
            errors++; $display("FAIL abort_res got %h exp 0000", res_val);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (ctx_done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL abort_no_done got done=%b busy=%b exp 0/0", ctx_done, busy);
            end
        end
    endtask

    task automatic test_bypass();
        load_res(16'h0077);
        cpyin = 1'b1; reg_sel = 3'd5; #1;
        checks++;
`ifdef ACC_REG_FILE_BYPASS_EN
        if (reg_val !== 16'h0077) begin
            errors++; $display("FAIL bypass_same_cycle got %h exp 0077", reg_val);
        end
`else
        if (reg_val !== 16'h0000) begin
            errors++; $display("FAIL no_bypass_same_cycle got %h exp 0000", reg_val);
        end
`endif
        tick();
        cpyin = 1'b0; #1;
        checks++;
        if (reg_val !== 16'h0077) begin
            errors++; $display("FAIL cpyin_sel5 got %h exp 0077", reg_val);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_copy();
        test_comp();
        test_save();
        test_restore();
        test_reset_abort();
        test_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
